md_sched: RTL and testbench

//  Execute-stage scheduler for the multiply/divide unit and HI/LO registers.

---
 rtl/md_sched.sv | 143 ++++++++++++++
 tb/tb_md_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched: E-stage multiply/divide scheduler owning HI/LO and the D-stage stall.
// Results are computed at issue and held until the fixed-latency busy window expires.
module md_sched #(
   parameter int MUL_CYC = 5,
   parameter int DIV_CYC = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        d_md_use,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   // state | meaning
   // IDLE  | nothing in flight; accepts mult/div/mthi/mtlo
   // RUN   | busy window; cnt counts down to the commit edge
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int CNT_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   pend_hi;
   logic [31:0]   pend_lo;
   logic          pend_wr;

   logic          is_md;
   logic          is_div;
   logic          div_zero;
   logic          div_ovf;
   logic [31:0]   dvs_s;
   logic [31:0]   dvs_u;
   logic [63:0]   prod_s;
   logic [63:0]   prod_u;
   logic [31:0]   quo_s;
   logic [31:0]   rem_s;
   logic [31:0]   quo_u;
   logic [31:0]   rem_u;
   logic [31:0]   res_hi;
   logic [31:0]   res_lo;
   logic [CW-1:0] res_n;

   assign is_md    = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
   assign is_div   = (md_op == OP_DIV) || (md_op == OP_DIVU);
   assign md_stall = d_md_use & (busy | (start & is_md));

   assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
   assign prod_u = {32'd0, src_a} * {32'd0, src_b};

   // Zero and overflow divisors are swapped for 1: zero results are discarded at commit,
   // and a/1 already yields the required 0x80000000 quotient with zero remainder.
   assign div_zero = (src_b == 32'd0);
   assign div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
   assign dvs_s    = (div_zero || div_ovf) ? 32'd1 : src_b;
   assign dvs_u    = div_zero ? 32'd1 : src_b;

   assign quo_s = $signed(src_a) / $signed(dvs_s);
   assign rem_s = $signed(src_a) % $signed(dvs_s);
   assign quo_u = src_a / dvs_u;
   assign rem_u = src_a % dvs_u;

   always_comb begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
      res_n  = CW'(MUL_CYC - 1);
      case (md_op)
         OP_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         OP_DIV: begin
            res_hi = rem_s;
            res_lo = quo_s;
            res_n  = CW'(DIV_CYC - 1);
         end
         OP_DIVU: begin
            res_hi = rem_u;
            res_lo = quo_u;
            res_n  = CW'(DIV_CYC - 1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (is_md) begin
                     pend_hi <= res_hi;
                     pend_lo <= res_lo;
                     pend_wr <= !(is_div && div_zero);
                     cnt     <= res_n;
                     busy    <= 1'b1;
                     state   <= RUN;
                  end else if (md_op == OP_MTHI) begin
                     hi <= src_a;
                  end else if (md_op == OP_MTLO) begin
                     lo <= src_a;
                  end
               end
            end
            RUN: begin
               if (cnt == '0) begin
                  if (pend_wr) begin
                     hi <= pend_hi;
                     lo <= pend_lo;
                  end
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed and random stimulus against an arithmetic reference model;
// expected commits are queued at issue and popped when the DUT drops busy.
module tb_md_sched;
   localparam int MUL_CYC = 5;
   localparam int DIV_CYC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] src_a = 32'd0;
   logic [31:0] src_b = 32'd0;
   logic        d_md_use = 1'b0;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail = 0;

   md_sched #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .src_a(src_a), .src_b(src_b), .d_md_use(d_md_use),
      .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } res_t;

   res_t        sb_q[$];
   res_t        m_pend;
   int          m_left = 0;
   logic [31:0] c_hi = 32'd0;
   logic [31:0] c_lo = 32'd0;
   bit          rst_hit = 1'b0;
   bit          prev_busy = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic res_t model_op(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                     logic [31:0] old_hi, logic [31:0] old_lo);
      res_t        r;
      longint      sa, sb, p;
      logic [63:0] ua, ub, pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r.hi = old_hi;
      r.lo = old_lo;
      case (op)
         3'd1: begin
            p = sa * sb;
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         3'd2: begin
            pu = ua * ub;
            r.hi = pu[63:32];
            r.lo = pu[31:0];
         end
         3'd3: if (b != 32'd0) begin
            r.lo = 32'(sa / sb);
            r.hi = 32'(sa % sb);
         end
         3'd4: if (b != 32'd0) begin
            r.lo = 32'(ua / ub);
            r.hi = 32'(ua % ub);
         end
         default: ;
      endcase
      return r;
   endfunction

   // Reference model: architectural HI/LO plus cycles left in the busy window.
   always @(posedge clk) begin
      rst_hit = !reset;
      if (!reset) begin
         m_left = 0;
         c_hi = 32'd0;
         c_lo = 32'd0;
         sb_q.delete();
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            c_hi = m_pend.hi;
            c_lo = m_pend.lo;
         end
      end else if (start) begin
         if (md_op inside {[3'd1:3'd4]}) begin
            m_pend = model_op(md_op, src_a, src_b, c_hi, c_lo);
            sb_q.push_back(m_pend);
            m_left = (md_op <= 3'd2) ? MUL_CYC : DIV_CYC;
         end else if (md_op == 3'd5) begin
            c_hi = src_a;
         end else if (md_op == 3'd6) begin
            c_lo = src_a;
         end
      end
   end

   always @(negedge clk) begin
      bit   exp_busy;
      bit   exp_stall;
      res_t e;
      exp_busy  = (m_left > 0);
      exp_stall = d_md_use & (exp_busy | (start & (md_op inside {[3'd1:3'd4]})));
      check("busy", 32'(busy), 32'(exp_busy));
      check("md_stall", 32'(md_stall), 32'(exp_stall));
      check("hi_arch", hi, c_hi);
      check("lo_arch", lo, c_lo);
      if (prev_busy && !busy && !rst_hit) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL commit: DUT committed hi %h lo %h, required no commit", hi, lo);
         end else begin
            e = sb_q.pop_front();
            check("commit_hi", hi, e.hi);
            check("commit_lo", lo, e.lo);
         end
      end
      prev_busy = busy;
   end

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      start = 1'b1;
      md_op = op;
      src_a = a;
      src_b = b;
      tick();
      start = 1'b0;
      md_op = 3'd0;
      src_a = $urandom();
      src_b = $urandom();
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy && cycles < 64) begin
         cycles++;
         tick();
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle: busy %0b after %0d cycles, required 0", busy, cycles);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int          cyc;
      int          stalls;
      logic [2:0]  op;
      logic [31:0] a, b;

      // Reset held over a MULT start: nothing may be accepted or committed.
      start = 1'b1;
      md_op = 3'd1;
      src_a = 32'h1234_5678;
      src_b = 32'h0000_0010;
      tick(2);
      start = 1'b0;
      md_op = 3'd0;
      reset = 1'b1;
      tick(8);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);

      issue(3'd1, 32'hFFFF_FFFE, 32'd3);
      wait_idle(cyc);
      check("mult_len", 32'(cyc), 32'(MUL_CYC));
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFA);
      issue(3'd2, 32'hFFFF_FFFE, 32'd3);
      wait_idle(cyc);
      check("multu_hi", hi, 32'h0000_0002);
      check("multu_lo", lo, 32'hFFFF_FFFA);

      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle(cyc);
      check("div_len", 32'(cyc), 32'(DIV_CYC));
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);
      issue(3'd4, 32'd7, 32'd0);
      wait_idle(cyc);
      check("divu0_len", 32'(cyc), 32'(DIV_CYC));
      check("divu0_hi", hi, 32'hFFFF_FFFF);
      check("divu0_lo", lo, 32'hFFFF_FFFD);
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(cyc);
      check("divovf_lo", lo, 32'h8000_0000);
      check("divovf_hi", hi, 32'd0);

      // Stall window: start cycle plus the full busy window.
      d_md_use = 1'b1;
      start = 1'b1;
      md_op = 3'd3;
      src_a = 32'd100;
      src_b = 32'd7;
      #1;
      stalls = md_stall ? 1 : 0;
      tick();
      start = 1'b0;
      md_op = 3'd0;
      while (md_stall && stalls < 40) begin
         stalls++;
         tick();
      end
      check("stall_len", 32'(stalls), 32'(DIV_CYC + 1));
      d_md_use = 1'b0;
      tick(2);
      stalls = 0;
      start = 1'b1;
      md_op = 3'd3;
      #1;
      for (int i = 0; i < DIV_CYC + 2; i++) begin
         if (md_stall) stalls++;
         tick();
         start = 1'b0;
         md_op = 3'd0;
      end
      check("nostall", 32'(stalls), 32'd0);
      tick(2);

      issue(3'd5, 32'h1234_5678, 32'd0);
      check("mthi_hi", hi, 32'h1234_5678);
      check("mthi_busy", 32'(busy), 32'd0);
      issue(3'd6, 32'hCAFE_0001, 32'd0);
      check("mtlo_lo", lo, 32'hCAFE_0001);

      // Second MULT issued mid-RUN must be dropped.
      issue(3'd1, 32'd6, 32'd7);
      tick(2);
      issue(3'd1, 32'd100, 32'd100);
      wait_idle(cyc);
      check("ignored_lo", lo, 32'd42);
      check("ignored_hi", hi, 32'd0);
      tick(MUL_CYC + 2);
      check("ignored_late_lo", lo, 32'd42);

      issue(3'd1, 32'd11, 32'd13);
      tick(2);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_hi", hi, 32'd0);
      check("midrst_lo", lo, 32'd0);
      tick(MUL_CYC + 2);
      check("midrst_late_lo", lo, 32'd0);
      issue(3'd2, 32'd5, 32'd6);
      wait_idle(cyc);
      check("fresh_len", 32'(cyc), 32'(MUL_CYC));
      check("fresh_lo", lo, 32'd30);
      check("fresh_hi", hi, 32'd0);

      // Reset sampled on the commit edge itself wins.
      issue(3'd1, 32'd9, 32'd9);
      tick(MUL_CYC - 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("rstcommit_lo", lo, 32'd0);
      check("rstcommit_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 80; i++) begin
         op = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         d_md_use = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 29) == 0) begin
            reset = 1'b0;
            tick();
            reset = 1'b1;
         end
         issue(op, a, b);
         tick($urandom_range(0, 12));
      end
      d_md_use = 1'b0;
      tick(DIV_CYC + 3);
      check("queue_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
